reg_ctrl_sequencer: RTL and testbench



---
 rtl/reg_ctrl_sequencer_pkg.sv | 46 ++++
 rtl/reg_ctrl_sequencer_if.sv | 40 ++++
 rtl/reg_ctrl_sequencer_decoder.sv | 41 ++++
 rtl/reg_ctrl_sequencer.sv | 109 ++++++++++
 tb/tb_reg_ctrl_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_ctrl_sequencer_pkg.sv
// Shared types for the register-file control sequencer: opcodes, FSM states,
// ALU function encodings and the EXEC strobe bundle.
package reg_ctrl_sequencer_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpGet  = 4'h1,
    OpPut  = 4'h2,
    OpLdi  = 4'h3,
    OpAdd  = 4'h4,
    OpSub  = 4'h5,
    OpAnd  = 4'h6,
    OpOr   = 4'h7,
    OpXor  = 4'h8,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StFetchImm,
    StExec,
    StHalted
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Everything the EXEC cycle needs to know about the latched opcode.
  typedef struct packed {
    logic       acc_we;
    logic       get;
    logic       put;
    logic       rd_oe;
    logic       status_we;
    logic [2:0] alu_op;
    logic       alu_oe;
    logic       imm_oe;
    logic       illegal;
    logic       halt;
  } exec_ctrl_t;

endpackage

// File: rtl/reg_ctrl_sequencer_if.sv
// Instruction-fetch handshake plus register-file/ALU control bus.
interface reg_ctrl_sequencer_if #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned I_ADDR_WIDTH   = 12,
  parameter int unsigned REG_ADDR_WIDTH = 4
);
  logic                      instr_req;
  logic [I_ADDR_WIDTH-1:0]   instr_addr;
  logic                      instr_ack;
  logic [DATA_W-1:0]         instr_data;

  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic                      acc_write_enable;
  logic                      read_get_to_acc;
  logic                      write_put_acc;
  logic                      read_data_output_enable;
  logic                      status_write_enable;
  logic [2:0]                alu_op;
  logic                      alu_result_oe;
  logic                      imm_oe;
  logic [DATA_W-1:0]         imm;

  // Sequencer side.
  modport master (
    output instr_req, instr_addr,
    input  instr_ack, instr_data,
    output reg_addr, acc_write_enable, read_get_to_acc, write_put_acc,
    output read_data_output_enable, status_write_enable, alu_op, alu_result_oe,
    output imm_oe, imm
  );

  // Instruction memory / register file side.
  modport slave (
    input  instr_req, instr_addr,
    output instr_ack, instr_data,
    input  reg_addr, acc_write_enable, read_get_to_acc, write_put_acc,
    input  read_data_output_enable, status_write_enable, alu_op, alu_result_oe,
    input  imm_oe, imm
  );
endinterface

// File: rtl/reg_ctrl_sequencer_decoder.sv
// Combinational map from a latched opcode to its EXEC strobe bundle.
module reg_ctrl_sequencer_decoder
  import reg_ctrl_sequencer_pkg::*;
(
  input  logic [3:0] i_opcode,
  output exec_ctrl_t o_ctrl
);

  // Decode opcode; undefined codes only raise the illegal flag.
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OpNop: ;
      OpGet: begin
        o_ctrl.get    = 1'b1;
        o_ctrl.acc_we = 1'b1;
      end
      OpPut: o_ctrl.put = 1'b1;
      OpLdi: begin
        o_ctrl.imm_oe = 1'b1;
        o_ctrl.acc_we = 1'b1;
      end
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        o_ctrl.rd_oe     = 1'b1;
        o_ctrl.alu_oe    = 1'b1;
        o_ctrl.acc_we    = 1'b1;
        o_ctrl.status_we = 1'b1;
        case (i_opcode)
          OpSub:   o_ctrl.alu_op = ALU_SUB;
          OpAnd:   o_ctrl.alu_op = ALU_AND;
          OpOr:    o_ctrl.alu_op = ALU_OR;
          OpXor:   o_ctrl.alu_op = ALU_XOR;
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OpHalt:  o_ctrl.halt    = 1'b1;
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_ctrl_sequencer.sv
// Fetch/execute sequencer: fetches instruction bytes over req/ack, then issues
// one EXEC cycle of register-file control strobes per instruction.
module reg_ctrl_sequencer
  import reg_ctrl_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned I_ADDR_WIDTH   = 12,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  reg_ctrl_sequencer_if.master bus,
  output logic                 halted,
  output logic                 illegal_instr
);

  state_e                  r_state, w_state_next;
  logic [I_ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [DATA_W-1:0]       r_instr, w_instr_next;
  logic [DATA_W-1:0]       r_imm, w_imm_next;
  exec_ctrl_t              w_ctrl;

  reg_ctrl_sequencer_decoder u_decoder (
    .i_opcode (r_instr[7:4]),
    .o_ctrl   (w_ctrl)
  );

  assign bus.instr_addr = r_pc;
  assign bus.imm        = r_imm;

  // State, pc and latched instruction/immediate registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_instr <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_imm   <= w_imm_next;
    end
  end

  // Next-state logic and all strobes; strobes only leave zero during EXEC.
  always_comb begin
    w_state_next                = r_state;
    w_pc_next                   = r_pc;
    w_instr_next                = r_instr;
    w_imm_next                  = r_imm;
    bus.instr_req               = 1'b0;
    bus.reg_addr                = '0;
    bus.acc_write_enable        = 1'b0;
    bus.read_get_to_acc         = 1'b0;
    bus.write_put_acc           = 1'b0;
    bus.read_data_output_enable = 1'b0;
    bus.status_write_enable     = 1'b0;
    bus.alu_op                  = '0;
    bus.alu_result_oe           = 1'b0;
    bus.imm_oe                  = 1'b0;
    halted                      = 1'b0;
    illegal_instr               = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (run) w_state_next = StFetch;
      end
      StFetch: begin
        bus.instr_req = 1'b1;
        if (bus.instr_ack) begin
          w_instr_next = bus.instr_data;
          w_pc_next    = r_pc + I_ADDR_WIDTH'(1);
          w_state_next = (bus.instr_data[7:4] == OpLdi) ? StFetchImm : StExec;
        end
      end
      StFetchImm: begin
        bus.instr_req = 1'b1;
        if (bus.instr_ack) begin
          w_imm_next   = bus.instr_data;
          w_pc_next    = r_pc + I_ADDR_WIDTH'(1);
          w_state_next = StExec;
        end
      end
      StExec: begin
        bus.reg_addr                = REG_ADDR_WIDTH'(r_instr[3:0]);
        bus.acc_write_enable        = w_ctrl.acc_we;
        bus.read_get_to_acc         = w_ctrl.get;
        bus.write_put_acc           = w_ctrl.put;
        bus.read_data_output_enable = w_ctrl.rd_oe;
        bus.status_write_enable     = w_ctrl.status_we;
        bus.alu_op                  = w_ctrl.alu_op;
        bus.alu_result_oe           = w_ctrl.alu_oe;
        bus.imm_oe                  = w_ctrl.imm_oe;
        illegal_instr               = w_ctrl.illegal;
        if (w_ctrl.halt)  w_state_next = StHalted;
        else if (run)     w_state_next = StFetch;
        else              w_state_next = StIdle;
      end
      StHalted: begin
        // Sticky until reset.
        halted = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Randomized bench for reg_ctrl_sequencer with an instruction-level reference
// model and a behavioural instruction memory.
module tb_reg_ctrl_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic halted, illegal_instr;

  reg_ctrl_sequencer_if #(.DATA_W(DW), .I_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) bus ();

  reg_ctrl_sequencer #(.DATA_W(DW), .I_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .bus           (bus),
    .halted        (halted),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // Program memory and per-address ack wait (cycles of req before ack).
  logic [7:0]  mem      [4096];
  int unsigned wait_tab [4096];

  // Reference model: what the sequencer should be doing this cycle.
  typedef enum logic [2:0] {PhIdle, PhOp, PhImm, PhExec, PhHalt} phase_t;
  phase_t      m_phase;
  logic [11:0] m_pc;
  logic [7:0]  m_op;
  logic [7:0]  m_imm;
  int unsigned m_wait;

  int unsigned cfg_run_pct;
  int unsigned cfg_stray_pct;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_vec(
    input logic hl, input logic ill, input logic req, input logic [11:0] addr,
    input logic [3:0] ra, input logic accw, input logic get, input logic put,
    input logic rdoe, input logic swe, input logic [2:0] aop, input logic aoe,
    input logic ioe, input logic [7:0] im);
    return {27'd0, hl, ill, req, addr, ra, accw, get, put, rdoe, swe, aop, aoe, ioe, im};
  endfunction

  function automatic logic [63:0] observed();
    return pack_vec(halted, illegal_instr, bus.instr_req, bus.instr_addr, bus.reg_addr,
                    bus.acc_write_enable, bus.read_get_to_acc, bus.write_put_acc,
                    bus.read_data_output_enable, bus.status_write_enable, bus.alu_op,
                    bus.alu_result_oe, bus.imm_oe, bus.imm);
  endfunction

  // Expected outputs derived from the instruction semantics.
  function automatic logic [63:0] expected();
    logic hl, ill, req, accw, get, put, rdoe, swe, aoe, ioe;
    logic [3:0] ra;
    logic [2:0] aop;
    int opc;
    hl = 0; ill = 0; req = 0; accw = 0; get = 0; put = 0;
    rdoe = 0; swe = 0; aoe = 0; ioe = 0; ra = '0; aop = '0;
    opc = int'(m_op[7:4]);
    case (m_phase)
      PhOp, PhImm: req = 1;
      PhHalt:      hl = 1;
      PhExec: begin
        ra = m_op[3:0];
        if (opc == 1) begin get = 1; accw = 1; end
        else if (opc == 2) put = 1;
        else if (opc == 3) begin ioe = 1; accw = 1; end
        else if (opc >= 4 && opc <= 8) begin
          rdoe = 1; aoe = 1; accw = 1; swe = 1; aop = 3'(opc - 4);
        end
        else if (opc != 0 && opc != 15) ill = 1;
      end
      default: ;
    endcase
    return pack_vec(hl, ill, req, m_pc, ra, accw, get, put, rdoe, swe, aop, aoe, ioe, m_imm);
  endfunction

  function automatic void model_reset();
    m_phase = PhIdle;
    m_pc    = '0;
    m_op    = '0;
    m_imm   = '0;
    m_wait  = 0;
  endfunction

  // One clock: check this cycle's outputs, drive inputs, advance the model.
  task automatic step();
    logic       ack;
    logic [7:0] data;
    int         ncont;
    @(negedge clk);
    check_eq("cycle", observed(), expected());
    if (m_phase == PhExec) begin
      ncont = int'(bus.read_get_to_acc) + int'(bus.alu_result_oe) + int'(bus.imm_oe);
      check_eq("bus_contention", 64'(ncont > 1), 64'(0));
    end
    run  = ($urandom_range(99) < cfg_run_pct);
    ack  = 1'b0;
    data = 8'($urandom);
    if (m_phase == PhOp || m_phase == PhImm) begin
      if (m_wait == 0) begin
        ack  = 1'b1;
        data = mem[m_pc];
      end else begin
        m_wait--;
      end
    end else if ($urandom_range(99) < cfg_stray_pct) begin
      ack = 1'b1;
    end
    bus.instr_ack  = ack;
    bus.instr_data = data;

    case (m_phase)
      PhIdle: if (run) begin m_phase = PhOp; m_wait = wait_tab[m_pc]; end
      PhOp: if (ack) begin
        m_op = data;
        m_pc = m_pc + 12'd1;
        if (data[7:4] == 4'h3) begin m_phase = PhImm; m_wait = wait_tab[m_pc]; end
        else m_phase = PhExec;
      end
      PhImm: if (ack) begin
        m_imm   = data;
        m_pc    = m_pc + 12'd1;
        m_phase = PhExec;
      end
      PhExec: begin
        if (m_op[7:4] == 4'hF) m_phase = PhHalt;
        else if (run) begin m_phase = PhOp; m_wait = wait_tab[m_pc]; end
        else m_phase = PhIdle;
      end
      default: ;
    endcase
  endtask

  // Assert reset part-way through a clock high phase, check, then release.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("reset_async", observed(), expected());
    bus.instr_ack = 1'b0;
    run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clear_program();
    for (int i = 0; i < 4096; i++) begin
      mem[i]      = 8'h00;
      wait_tab[i] = 0;
    end
  endtask

  initial begin
    logic [7:0] b;
    bus.instr_ack  = 1'b0;
    bus.instr_data = '0;
    cfg_run_pct    = 100;
    cfg_stray_pct  = 0;
    model_reset();

    // GET R5; LDI 0xA5; SUB R3 with 3-cycle ack; illegal 0xB0; HALT.
    clear_program();
    mem[0] = 8'h15; mem[1] = 8'h30; mem[2] = 8'hA5; mem[3] = 8'h53;
    mem[4] = 8'hB0; mem[5] = 8'hF0;
    wait_tab[3] = 2;
    apply_reset();
    repeat (40) step();

    // Reset while a fetch is pending, then a stray ack must be ignored.
    clear_program();
    mem[0] = 8'h15;
    wait_tab[0] = 3;
    apply_reset();
    repeat (3) step();
    apply_reset();
    cfg_run_pct   = 0;
    cfg_stray_pct = 100;
    repeat (4) step();
    cfg_run_pct   = 100;
    cfg_stray_pct = 0;
    repeat (8) step();

    // Run NOPs up to pc=0xFFF where PUT R10 sits, then wrap to 0.
    clear_program();
    mem[12'hFFF] = 8'h2A;
    mem[0]       = 8'h30;
    mem[1]       = 8'h5C;
    apply_reset();
    repeat (2 * 4096 + 8) step();

    // Randomized programs, wait states, run gaps and stray acks.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4096; i++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hF && $urandom_range(31) != 0) b[7:4] = 4'h0;
        mem[i]      = b;
        wait_tab[i] = $urandom_range(3);
      end
      cfg_run_pct   = 85;
      cfg_stray_pct = 20;
      apply_reset();
      repeat (600) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
